// File: rtl/serial_adder_tx.sv
// Serial add protocol transmitter: serializes a parallel operand pair LSB-first
// into a bit-serial adder and reassembles the returned sum bits into a parallel result.
//
// state | meaning
// IDLE  | up_rdy=1, waiting for an operand pair
// SEND  | one vld beat per unstalled cycle, LSB first, until the MSB beat
module serial_adder_tx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [W-1:0] up_a,
  input  logic [W-1:0] up_b,
  input  logic         stall,
  output logic         vld,
  output logic         a,
  output logic         b,
  output logic         last,
  input  logic         sum,
  output logic         res_vld,
  output logic [W-1:0] res
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res_sh;
  logic [W-1:0]  res_sh_nxt;
  logic          beat_last;

  assign up_rdy    = (state == ST_IDLE);
  assign vld       = (state == ST_SEND) & ~stall;
  assign a         = vld & a_sh[0];
  assign b         = vld & b_sh[0];
  assign beat_last = (cnt == CNT_LAST);
  assign last      = vld & beat_last;

  // Sum bits arrive LSB first, so each new bit enters at the MSB end.
  generate
    if (W == 1) begin : g_res_w1
      assign res_sh_nxt = sum;
    end else begin : g_res_wn
      assign res_sh_nxt = {sum, res_sh[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      res     <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (up_vld) begin
            a_sh  <= up_a;
            b_sh  <= up_b;
            cnt   <= '0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (vld) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_sh_nxt;
            cnt    <= cnt + CW'(1);
            if (beat_last) begin
              state   <= ST_IDLE;
              res     <= res_sh_nxt;
              res_vld <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
